// File: rtl/fifo_scoreboard.sv
// Reference-model scoreboard for a synchronous FIFO: mirrors pushes/pops,
// compares popped data and flags against an internal queue, and keeps sticky error bits.
module fifo_scoreboard #(
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_SIZE  = 4,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 1,
  parameter int CNT_SIZE   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [DATA_SIZE-1:0] rd_data,
  input  logic                 full,
  input  logic                 empty,
  output logic [ADDR_SIZE:0]   level,
  output logic [DATA_SIZE-1:0] exp_data,
  output logic                 mismatch,
  output logic [CNT_SIZE-1:0]  match_cnt,
  output logic [CNT_SIZE-1:0]  mismatch_cnt,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic                 err_flag
);

  localparam logic [ADDR_SIZE:0] LVL_MAX = (ADDR_SIZE+1)'(DEPTH);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
  logic                 lvl_full, lvl_empty, push, pop;
  logic                 cmp_vld, cmp_neq, chk_en;
  logic [DATA_SIZE-1:0] cmp_exp;

  assign lvl_full  = (level == LVL_MAX);
  assign lvl_empty = (level == '0);
  assign pop       = rd_en & ~lvl_empty;
  // A write at full is still accepted when the same cycle frees a slot.
  assign push      = wr_en & (~lvl_full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  generate
    if (RD_LATENCY == 0) begin : g_lat0
      assign cmp_vld = pop;
      assign cmp_exp = mem[rd_ptr];
    end else begin : g_lat1
      logic                 vld_q;
      logic [DATA_SIZE-1:0] exp_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= 1'b0;
          exp_q <= '0;
        end else begin
          vld_q <= pop;
          exp_q <= mem[rd_ptr];
        end
      end
      assign cmp_vld = vld_q;
      assign cmp_exp = exp_q;
    end
  endgenerate

  assign cmp_neq = (rd_data != cmp_exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_data     <= '0;
      mismatch     <= 1'b0;
      match_cnt    <= '0;
      mismatch_cnt <= '0;
    end else begin
      mismatch <= cmp_vld & cmp_neq;
      if (cmp_vld) begin
        exp_data <= cmp_exp;
        if (!cmp_neq && match_cnt != '1)   match_cnt    <= match_cnt + 1'b1;
        if (cmp_neq && mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
      end
    end
  end

  // chk_en masks the flag check for the first cycle after reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_en        <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_flag      <= 1'b0;
    end else begin
      chk_en <= 1'b1;
      if (wr_en && lvl_full && !pop) err_overflow  <= 1'b1;
      if (rd_en && lvl_empty)        err_underflow <= 1'b1;
      if (chk_en && ((full != lvl_full) || (empty != lvl_empty))) err_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_scoreboard.sv
// Directed bench for fifo_scoreboard (RD_LATENCY=1, 16-deep, 8-bit data, 16-bit counters).
module tb_fifo_scoreboard;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0, full = 1'b0, empty = 1'b1;
  logic [7:0] wr_data = '0, rd_data = '0;
  logic [4:0] level;
  logic [7:0] exp_data;
  logic       mismatch, err_overflow, err_underflow, err_flag;
  logic [15:0] match_cnt, mismatch_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int tb_lvl = 0;   // occupancy the observed FIFO would report, used to drive its flags

  fifo_scoreboard #(.DATA_SIZE(8), .ADDR_SIZE(4), .DEPTH(16), .RD_LATENCY(1), .CNT_SIZE(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
    .full(full), .empty(empty), .level(level), .exp_data(exp_data), .mismatch(mismatch),
    .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_flag(err_flag));

  always #5 clk = ~clk;

  // One clock: drive inputs, flags from the pre-edge occupancy, then sample #1 after the edge.
  task step(input logic w, input logic [7:0] wd, input logic r, input logic [7:0] rdd,
            input logic bad_empty = 1'b0);
    logic p;
    wr_en = w; wr_data = wd; rd_en = r; rd_data = rdd;
    full  = (tb_lvl == 16);
    empty = (tb_lvl == 0) ^ bad_empty;
    p = r && tb_lvl > 0;
    if (w && (tb_lvl < 16 || p) && !p) tb_lvl++;
    else if (p && !(w && (tb_lvl < 16 || p))) tb_lvl--;
    @(posedge clk); #1;
  endtask

  task do_reset();
    rst = 1'b1;
    step(0, 8'h00, 0, 8'h00);
    rst = 1'b0;
    tb_lvl = 0;
  endtask

  task test_reset();
    do_reset();
    n_chk++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_chk++; if (match_cnt !== 16'd0 || mismatch_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %h/%h want 0/0", match_cnt, mismatch_cnt); end
    n_chk++; if ({mismatch, err_overflow, err_underflow, err_flag} !== 4'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0000", {mismatch, err_overflow, err_underflow, err_flag}); end
    n_chk++; if (exp_data !== 8'h00) begin n_fail++; $display("FAIL reset_exp: got %h want 00", exp_data); end
  endtask

  task test_fill_drain();
    logic [7:0] w;
    for (int i = 0; i < 16; i++) begin
      w = (i == 15) ? 8'h10 : 8'h11 + 8'(i);
      step(1, w, 0, 8'h00);
    end
    n_chk++; if (level !== 5'd16) begin n_fail++; $display("FAIL fill_level: got %0d want 16", level); end
    for (int i = 0; i < 17; i++) begin
      // rd_data carries the word popped on the previous cycle
      w = (i == 0) ? 8'h00 : (i == 16) ? 8'h10 : 8'h10 + 8'(i);
      step(0, 8'h00, i < 16, w);
    end
    n_chk++; if (match_cnt !== 16'd16) begin n_fail++; $display("FAIL drain_match: got %0d want 16", match_cnt); end
    n_chk++; if (mismatch_cnt !== 16'd0) begin n_fail++; $display("FAIL drain_mismatch: got %0d want 0", mismatch_cnt); end
    n_chk++; if (level !== 5'd0) begin n_fail++; $display("FAIL drain_level: got %0d want 0", level); end
    n_chk++; if ({err_overflow, err_underflow, err_flag} !== 3'b0) begin n_fail++; $display("FAIL drain_err: got %b want 000", {err_overflow, err_underflow, err_flag}); end
    n_chk++; if (exp_data !== 8'h10) begin n_fail++; $display("FAIL drain_exp: got %h want 10", exp_data); end
  endtask

  task test_mismatch();
    step(1, 8'hA5, 0, 8'h00);
    step(0, 8'h00, 1, 8'h00);
    n_chk++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL mm_early: got %b want 0", mismatch); end
    step(0, 8'h00, 0, 8'h5A);
    n_chk++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL mm_pulse: got %b want 1", mismatch); end
    n_chk++; if (mismatch_cnt !== 16'd1) begin n_fail++; $display("FAIL mm_cnt: got %0d want 1", mismatch_cnt); end
    n_chk++; if (exp_data !== 8'hA5) begin n_fail++; $display("FAIL mm_exp: got %h want a5", exp_data); end
    n_chk++; if (match_cnt !== 16'd16) begin n_fail++; $display("FAIL mm_match: got %0d want 16", match_cnt); end
    step(0, 8'h00, 0, 8'h5A);
    n_chk++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL mm_one_cycle: got %b want 0", mismatch); end
  endtask

  task test_overflow();
    logic [7:0] w;
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 8'h40 + 8'(i), 0, 8'h00);
    n_chk++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", err_overflow); end
    step(1, 8'hEE, 0, 8'h00);
    n_chk++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", err_overflow); end
    n_chk++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovf_level: got %0d want 16", level); end
    // simultaneous push/pop at full: pops 0x40, stores 0x77 into slot 0
    step(1, 8'h77, 1, 8'h00);
    n_chk++; if (level !== 5'd16) begin n_fail++; $display("FAIL fullrw_level: got %0d want 16", level); end
    for (int i = 0; i < 17; i++) begin
      w = (i == 16) ? 8'h77 : 8'h40 + 8'(i);
      step(0, 8'h00, i < 16, w);
    end
    n_chk++; if (match_cnt !== 16'd17) begin n_fail++; $display("FAIL wrap_match: got %0d want 17", match_cnt); end
    n_chk++; if (mismatch_cnt !== 16'd0) begin n_fail++; $display("FAIL wrap_mismatch: got %0d want 0", mismatch_cnt); end
    n_chk++; if (exp_data !== 8'h77) begin n_fail++; $display("FAIL wrap_exp: got %h want 77", exp_data); end
    n_chk++; if ({err_overflow, err_underflow, err_flag} !== 3'b100) begin n_fail++; $display("FAIL wrap_err: got %b want 100", {err_overflow, err_underflow, err_flag}); end
  endtask

  task test_underflow();
    do_reset();
    step(1, 8'h33, 1, 8'h00);
    n_chk++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL udf_set: got %b want 1", err_underflow); end
    n_chk++; if (level !== 5'd1) begin n_fail++; $display("FAIL udf_level: got %0d want 1", level); end
    step(0, 8'h00, 0, 8'h99);
    n_chk++; if (match_cnt !== 16'd0 || mismatch_cnt !== 16'd0) begin n_fail++; $display("FAIL udf_nocmp: got %0d/%0d want 0/0", match_cnt, mismatch_cnt); end
    n_chk++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL udf_ovf: got %b want 0", err_overflow); end
  endtask

  task test_flag_and_reset();
    do_reset();
    step(0, 8'h00, 0, 8'h00);
    n_chk++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL flag_early: got %b want 0", err_flag); end
    step(0, 8'h00, 0, 8'h00, 1'b1);
    n_chk++; if (err_flag !== 1'b1) begin n_fail++; $display("FAIL flag_set: got %b want 1", err_flag); end
    step(1, 8'h21, 0, 8'h00);
    step(0, 8'h00, 1, 8'h00);
    n_chk++; if (err_flag !== 1'b1) begin n_fail++; $display("FAIL flag_sticky: got %b want 1", err_flag); end
    // reset lands on the cycle that would carry the pending comparison
    rst = 1'b1;
    step(0, 8'h00, 0, 8'h21);
    rst = 1'b0; tb_lvl = 0;
    n_chk++; if ({level, exp_data, mismatch, err_overflow, err_underflow, err_flag} !== 17'd0) begin n_fail++; $display("FAIL midrst_out: got lvl=%0d exp=%h err=%b%b%b%b want all 0", level, exp_data, mismatch, err_overflow, err_underflow, err_flag); end
    n_chk++; if (match_cnt !== 16'd0 || mismatch_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d/%0d want 0/0", match_cnt, mismatch_cnt); end
    step(0, 8'h00, 0, 8'hFF);
    n_chk++; if (match_cnt !== 16'd0 || mismatch_cnt !== 16'd0 || mismatch !== 1'b0) begin n_fail++; $display("FAIL midrst_discard: got %0d/%0d mm=%b want 0/0 mm=0", match_cnt, mismatch_cnt, mismatch); end
  endtask

  task test_saturate();
    do_reset();
    step(1, 8'h3C, 0, 8'h3C);
    // steady push+pop at level 1: one matching comparison per cycle from the second pop on
    for (int i = 0; i < 65540; i++) step(1, 8'h3C, 1, 8'h3C);
    n_chk++; if (match_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_match: got %h want ffff", match_cnt); end
    n_chk++; if (mismatch_cnt !== 16'd0) begin n_fail++; $display("FAIL sat_mismatch: got %0d want 0", mismatch_cnt); end
    n_chk++; if ({err_overflow, err_underflow, err_flag} !== 3'b0) begin n_fail++; $display("FAIL sat_err: got %b want 000", {err_overflow, err_underflow, err_flag}); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_mismatch();
    test_overflow();
    test_underflow();
    test_flag_and_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
